imm_decode_stage: RTL and testbench

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/imm_decode_stage.sv | 199 +++++++++++++++++++
 tb/tb_imm_decode_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// -----------------------------------------------------------------------------
// imm_decode_stage
//
// Purpose:
//   Decodes the immediate of an instruction word and computes the
//   pc-relative target (pc + imm). The decoded pair is stored in a 2-entry
//   in-order FIFO with a valid/ready handshake on both sides.
//   Decode and add happen once, when the entry is pushed. The stored result
//   is presented downstream unchanged.
//
// Parameters:
//   XLEN        datapath width, 32 or 64
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset
//   flush       synchronous discard of all held entries (dominates push/pop)
//   in_valid    upstream entry present
//   in_ready    stage can accept an entry (registered state only)
//   in_inst     instruction word (compressed forms in [15:0])
//   in_type     immediate type: 0 NONE,1 I,2 S,3 B,4 U,5 J,6 CI,7 ZIMM
//   in_pc       instruction address
//   out_valid   head entry available
//   out_ready   downstream accepts head entry
//   out_imm     decoded immediate of head entry
//   out_target  pc + imm of head entry
//   out_type    immediate type of head entry
//   out_count   entries held (0..2)
// -----------------------------------------------------------------------------
module imm_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [2:0]      in_type,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic [2:0]      out_type,
  output logic [1:0]      out_count
);

  localparam logic [2:0] TYPE_NONE = 3'd0;
  localparam logic [2:0] TYPE_I    = 3'd1;
  localparam logic [2:0] TYPE_S    = 3'd2;
  localparam logic [2:0] TYPE_B    = 3'd3;
  localparam logic [2:0] TYPE_U    = 3'd4;
  localparam logic [2:0] TYPE_J    = 3'd5;
  localparam logic [2:0] TYPE_CI   = 3'd6;
  localparam logic [2:0] TYPE_ZIMM = 3'd7;

  // ---------------------------------------------------------------------------
  // Immediate decode (push side)
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_target;

  // The opcode size bits never contribute to any immediate.
  logic unused_inst_bits;
  assign unused_inst_bits = ^in_inst[1:0];

  // The U immediate already fills 32 bits, so it only needs sign extension
  // when the datapath is wider than that.
  generate
    if (XLEN > 32) begin : g_u_wide
      assign imm_u = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
    end else begin : g_u_narrow
      assign imm_u = {in_inst[31:12], 12'b0};
    end
  endgenerate

  always_comb begin
    dec_imm = '0;
    case (in_type)
      TYPE_NONE: dec_imm = '0;
      TYPE_I:    dec_imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
      TYPE_S:    dec_imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      TYPE_B:    dec_imm = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7],
                            in_inst[30:25], in_inst[11:8], 1'b0};
      TYPE_U:    dec_imm = imm_u;
      TYPE_J:    dec_imm = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                            in_inst[20], in_inst[30:21], 1'b0};
      TYPE_CI:   dec_imm = {{(XLEN-6){in_inst[12]}}, in_inst[12], in_inst[6:2]};
      TYPE_ZIMM: dec_imm = {{(XLEN-5){1'b0}}, in_inst[19:15]};
      default:   dec_imm = '0;
    endcase
  end

  // Wraps modulo 2^XLEN; carry out is intentionally dropped.
  assign dec_target = in_pc + dec_imm;

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic [1:0] count_q, count_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       push;
  logic       pop;

  // in_ready depends only on held state; rst_n gating makes it drop at once
  // while reset is asserted.
  assign in_ready  = rst_n && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_count = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      // Flush wins over any handshake in the same cycle.
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      count_d  = count_q + {1'b0, push} - {1'b0, pop};
      rd_ptr_d = rd_ptr_q ^ pop;
      wr_ptr_d = wr_ptr_q ^ push;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage: each slot holds the already-decoded result.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ent
      localparam logic ENT_IDX = 1'(gi);

      logic            we;
      logic [XLEN-1:0] imm_q,    imm_d;
      logic [XLEN-1:0] target_q, target_d;
      logic [2:0]      type_q,   type_d;

      assign we = push && !flush && (wr_ptr_q == ENT_IDX);

      always_comb begin
        imm_d    = imm_q;
        target_d = target_q;
        type_d   = type_q;
        if (we) begin
          imm_d    = dec_imm;
          target_d = dec_target;
          type_d   = in_type;
        end
      end

      // Reset clears the slots so the head reads as zero during reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          imm_q    <= '0;
          target_q <= '0;
          type_q   <= 3'd0;
        end else begin
          imm_q    <= imm_d;
          target_q <= target_d;
          type_q   <= type_d;
        end
      end
    end
  endgenerate

  // Head selection. Slot contents only change on a write to the tail slot,
  // so the head stays stable while it waits for out_ready.
  always_comb begin
    out_imm    = g_ent[0].imm_q;
    out_target = g_ent[0].target_q;
    out_type   = g_ent[0].type_q;
    if (rd_ptr_q) begin
      out_imm    = g_ent[1].imm_q;
      out_target = g_ent[1].target_q;
      out_type   = g_ent[1].type_q;
    end
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_decode_stage
//
// Drives a 32-bit and a 64-bit instance with identical stimulus and checks
// both against a queue-based model: directed vector table, hand-written
// handshake/flush/reset sequences, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [2:0]  in_type;
  logic [63:0] in_pc;
  logic        out_ready;

  logic        in_ready32, out_valid32;
  logic [31:0] out_imm32, out_target32;
  logic [2:0]  out_type32;
  logic [1:0]  out_count32;

  logic        in_ready64, out_valid64;
  logic [63:0] out_imm64, out_target64;
  logic [2:0]  out_type64;
  logic [1:0]  out_count64;

  logic [31:0] in_pc32;
  assign in_pc32 = in_pc[31:0];

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .in_type(in_type), .in_pc(in_pc32),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_target(out_target32),
    .out_type(out_type32), .out_count(out_count32)
  );

  imm_decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_type(in_type), .in_pc(in_pc),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_target(out_target64),
    .out_type(out_type64), .out_count(out_count64)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  t;
    logic [63:0] pc;
  } ent_t;

  ent_t mq[$];

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  t;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [63:0] tgt;
  } vec_t;

  vec_t tbl[12];

  // Immediate from the field layout: gather the field, then sign-correct it
  // arithmetically from its bit width (n = 0 means no sign extension).
  function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] t);
    longint v;
    int     n;
    v = 0;
    n = 0;
    case (t)
      3'd1: begin v = longint'(i[31:20]); n = 12; end
      3'd2: begin v = longint'({i[31:25], i[11:7]}); n = 12; end
      3'd3: begin v = longint'({i[31], i[7], i[30:25], i[11:8], 1'b0}); n = 13; end
      3'd4: begin v = longint'(i[31:12]) * 4096; n = 32; end
      3'd5: begin v = longint'({i[31], i[19:12], i[20], i[30:21], 1'b0}); n = 21; end
      3'd6: begin v = longint'({i[12], i[6:2]}); n = 6; end
      3'd7: begin v = longint'(i[19:15]); n = 0; end
      default: begin v = 0; n = 0; end
    endcase
    if (n > 0 && v >= (longint'(1) << (n - 1)))
      v = v - (longint'(1) << n);
    return 64'(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_state();
    logic [63:0] e_imm;
    logic [63:0] e_tgt;
    logic [31:0] e_tgt32;
    int sz;
    sz = mq.size();
    chk("count32", 64'(out_count32), 64'(sz));
    chk("count64", 64'(out_count64), 64'(sz));
    chk("valid32", 64'(out_valid32), 64'(sz != 0));
    chk("valid64", 64'(out_valid64), 64'(sz != 0));
    chk("ready32", 64'(in_ready32), 64'(sz < 2));
    chk("ready64", 64'(in_ready64), 64'(sz < 2));
    if (sz > 0) begin
      e_imm   = ref_imm(mq[0].inst, mq[0].t);
      e_tgt   = mq[0].pc + e_imm;
      e_tgt32 = mq[0].pc[31:0] + e_imm[31:0];
      chk("imm64", out_imm64, e_imm);
      chk("tgt64", out_target64, e_tgt);
      chk("type64", 64'(out_type64), 64'(mq[0].t));
      chk("imm32", 64'(out_imm32), 64'(e_imm[31:0]));
      chk("tgt32", 64'(out_target32), 64'(e_tgt32));
      chk("type32", 64'(out_type32), 64'(mq[0].t));
    end
  endtask

  // One clock cycle: drive inputs, check state at the falling edge, advance
  // the model to what the rising edge should produce.
  task automatic cycle(input logic v, input logic [31:0] inst, input logic [2:0] t,
                       input logic [63:0] pc, input logic ordy, input logic fl);
    bit   do_push;
    bit   do_pop;
    ent_t e;
    in_valid  = v;
    in_inst   = inst;
    in_type   = t;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    check_state();
    if (fl) begin
      mq.delete();
    end else begin
      do_push = v && (mq.size() < 2);
      do_pop  = ordy && (mq.size() > 0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.inst = inst; e.t = t; e.pc = pc;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, "_count32"}, 64'(out_count32), 64'd0);
    chk({tag, "_count64"}, 64'(out_count64), 64'd0);
    chk({tag, "_valid32"}, 64'(out_valid32), 64'd0);
    chk({tag, "_valid64"}, 64'(out_valid64), 64'd0);
    chk({tag, "_ready32"}, 64'(in_ready32), 64'd0);
    chk({tag, "_ready64"}, 64'(in_ready64), 64'd0);
    chk({tag, "_imm64"}, out_imm64, 64'd0);
    chk({tag, "_tgt64"}, out_target64, 64'd0);
    chk({tag, "_type64"}, 64'(out_type64), 64'd0);
    chk({tag, "_imm32"}, 64'(out_imm32), 64'd0);
    chk({tag, "_tgt32"}, 64'(out_target32), 64'd0);
    chk({tag, "_type32"}, 64'(out_type32), 64'd0);
  endtask

  initial begin
    tbl[0]  = '{32'hFFF00093, 3'd1, 64'h100,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_00FF};
    tbl[1]  = '{32'hFE000EE3, 3'd3, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_0FFC};
    tbl[2]  = '{32'h0080006F, 3'd5, 64'h200,  64'h8,                   64'h208};
    tbl[3]  = '{32'h800000B7, 3'd4, 64'h0,    64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000};
    tbl[4]  = '{32'h000F8000, 3'd7, 64'h4,    64'h1F,                  64'h23};
    tbl[5]  = '{32'h0000107D, 3'd6, 64'h8,    64'hFFFF_FFFF_FFFF_FFFF, 64'h7};
    tbl[6]  = '{32'hFE000C23, 3'd2, 64'h40,   64'hFFFF_FFFF_FFFF_FFF8, 64'h38};
    tbl[7]  = '{32'hFFFFFFFF, 3'd0, 64'h10,   64'h0,                   64'h10};
    tbl[8]  = '{32'h00000041, 3'd6, 64'h0,    64'h10,                  64'h10};
    tbl[9]  = '{32'hFFF00093, 3'd1, 64'h0,    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[10] = '{32'h800F8000, 3'd7, 64'h0,    64'h1F,                  64'h1F};
    tbl[11] = '{32'h12345037, 3'd4, 64'h4,    64'h1234_5000,           64'h1234_5004};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0;
    in_type = '0; in_pc = '0; out_ready = 1'b0;
    #1;
    check_reset_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors: push into an empty stage, check one cycle later, pop.
    for (int k = 0; k < 12; k++) begin
      cycle(1'b1, tbl[k].inst, tbl[k].t, tbl[k].pc, 1'b0, 1'b0);
      chk("tbl_valid", 64'(out_valid64), 64'd1);
      chk("tbl_imm64", out_imm64, tbl[k].imm);
      chk("tbl_tgt64", out_target64, tbl[k].tgt);
      chk("tbl_imm32", 64'(out_imm32), 64'(tbl[k].imm[31:0]));
      chk("tbl_tgt32", 64'(out_target32), 64'(tbl[k].tgt[31:0]));
      chk("tbl_type", 64'(out_type32), 64'(tbl[k].t));
      cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
    end

    // Back-pressure: A,B,C with out_ready low; C waits upstream.
    cycle(1'b1, 32'h00100093, 3'd1, 64'h10, 1'b0, 1'b0);
    cycle(1'b1, 32'h00200093, 3'd1, 64'h20, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 32'h00300093, 3'd1, 64'h30, 1'b0, 1'b0);
    chk("bp_c_held", 64'(mq.size()), 64'd2);
    cycle(1'b1, 32'h00300093, 3'd1, 64'h30, 1'b1, 1'b0);
    cycle(1'b1, 32'h00300093, 3'd1, 64'h30, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++)
      cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);

    // Count 1 with simultaneous push and pop for 8 cycles.
    cycle(1'b1, 32'h00000013, 3'd1, 64'h0, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++)
      cycle(1'b1, 32'(k) << 20, 3'd1, 64'(k * 4), 1'b1, 1'b0);
    cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);

    // Flush at count 2 with a push and pop offered: all discarded.
    cycle(1'b1, 32'hFFF00093, 3'd1, 64'h100, 1'b0, 1'b0);
    cycle(1'b1, 32'h0080006F, 3'd5, 64'h200, 1'b0, 1'b0);
    cycle(1'b1, 32'h800000B7, 3'd4, 64'h300, 1'b1, 1'b1);
    chk("flush_count", 64'(out_count64), 64'd0);
    cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream, away from any clock edge.
    cycle(1'b1, 32'hFFF00093, 3'd1, 64'h100, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000107D, 3'd6, 64'h8, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_zero("async_rst");
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(in_ready64), 64'd1);
    @(posedge clk);
    #1;

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom % 4) != 0, $urandom, 3'($urandom % 8),
            {$urandom, $urandom}, ($urandom % 3) != 0, ($urandom % 20) == 0);
    end
    for (int k = 0; k < 3; k++)
      cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
